// File: rtl/loop_addr_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | loop_addr_stack: LIFO of loop-start addresses feeding the PC loop-back.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module loop_addr_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         clear_err,
  output logic [WIDTH-1:0]             top,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic               w_empty;
  logic               w_full;
  logic [c_ptr_w-1:0] w_top_idx;
  logic [c_ptr_w-1:0] w_wr_idx;

  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == c_cnt_w'(DEPTH));
  // count itself is the pointer; only used when the index is in range
  assign w_top_idx = c_ptr_w'(count_q - c_cnt_w'(1));
  assign w_wr_idx  = c_ptr_w'(count_q);

  always_comb begin
    mem_d       = mem_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~clear_err;
    underflow_d = underflow_q & ~clear_err;
    case ({push, pop})
      2'b10: begin
        if (!w_full) begin
          mem_d[w_wr_idx] = push_data;
          count_d         = count_q + c_cnt_w'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end
      2'b01: begin
        if (!w_empty) begin
          count_d = count_q - c_cnt_w'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end
      2'b11: begin
        // Replace-top is legal even when full; from empty it degrades to a push
        if (!w_empty) begin
          mem_d[w_top_idx] = push_data;
        end else begin
          mem_d[0]    = push_data;
          count_d     = c_cnt_w'(1);
          underflow_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_q <= mem_d;
    end
  end

  assign top       = w_empty ? '0 : mem_q[w_top_idx];
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_loop_addr_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_loop_addr_stack: scoreboard bench with a queue-based LIFO model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_loop_addr_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               push = 1'b0;
  logic               pop = 1'b0;
  logic [WIDTH-1:0]   push_data = '0;
  logic               clear_err = 1'b0;
  logic [WIDTH-1:0]   top;
  logic               empty;
  logic               full;
  logic [c_cnt_w-1:0] count;
  logic               overflow;
  logic               underflow;

  loop_addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .clear_err (clear_err),
    .top       (top),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]   top;
    logic               empty;
    logic               full;
    logic [c_cnt_w-1:0] count;
    logic               ovf;
    logic               unf;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model: a plain queue of addresses plus two sticky bits
  logic [WIDTH-1:0] stk[$];
  bit               m_ovf = 0;
  bit               m_unf = 0;

  task automatic model_apply(input logic p, input logic o, input logic [WIDTH-1:0] d,
                             input logic c, input logic r);
    bit ov_ev;
    bit un_ev;
    ov_ev = 0;
    un_ev = 0;
    if (!r) begin
      stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (p && !o) begin
        if (stk.size() < DEPTH) stk.push_back(d);
        else ov_ev = 1;
      end else if (!p && o) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else un_ev = 1;
      end else if (p && o) begin
        if (stk.size() > 0) stk[stk.size()-1] = d;
        else begin
          stk.push_back(d);
          un_ev = 1;
        end
      end
      m_ovf = ov_ev | (m_ovf & !c);
      m_unf = un_ev | (m_unf & !c);
    end
  endtask

  task automatic step(input logic p, input logic o, input logic [WIDTH-1:0] d,
                      input logic c, input logic r, input string nm);
    exp_t e;
    @(negedge clk);
    push      = p;
    pop       = o;
    push_data = d;
    clear_err = c;
    rst_n     = r;
    @(posedge clk);
    #1;
    model_apply(p, o, d, c, r);
    e.top   = (stk.size() > 0) ? stk[stk.size()-1] : '0;
    e.empty = (stk.size() == 0);
    e.full  = (stk.size() == DEPTH);
    e.count = c_cnt_w'(stk.size());
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: one expectation retires per cycle, sampled on the falling edge
  exp_t  mon_e;
  string mon_n;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      tests++;
      if (top !== mon_e.top || empty !== mon_e.empty || full !== mon_e.full ||
          count !== mon_e.count || overflow !== mon_e.ovf || underflow !== mon_e.unf) begin
        fails++;
        $display("FAIL %s: got top=%h cnt=%0d e=%b f=%b ov=%b un=%b, want top=%h cnt=%0d e=%b f=%b ov=%b un=%b",
                 mon_n, top, count, empty, full, overflow, underflow,
                 mon_e.top, mon_e.count, mon_e.empty, mon_e.full, mon_e.ovf, mon_e.unf);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] v10_30 [3];
    bit rp, ro;
    v10_30[0] = 8'h10;
    v10_30[1] = 8'h20;
    v10_30[2] = 8'h30;

    step(0, 0, 8'h00, 0, 0, "reset");
    step(0, 0, 8'h00, 0, 1, "idle_after_reset");

    for (int i = 0; i < 3; i++) step(1, 0, v10_30[i], 0, 1, "push_seq");
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, 1, "pop_seq");

    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i), 0, 1, "fill");
    step(1, 0, 8'hAA, 0, 1, "push_when_full");
    step(1, 1, 8'hBB, 0, 1, "replace_when_full");
    step(0, 0, 8'h00, 0, 1, "overflow_sticky");
    step(0, 0, 8'h00, 1, 1, "clear_overflow");

    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0, 1, "drain");
    step(0, 1, 8'h00, 0, 1, "pop_empty");
    step(0, 1, 8'h00, 1, 1, "clear_with_pop");
    step(0, 0, 8'h00, 1, 1, "clear_underflow");
    step(1, 1, 8'h55, 0, 1, "pushpop_empty");

    step(0, 0, 8'h00, 0, 0, "reset2");
    step(1, 0, 8'h01, 0, 1, "push_01");
    step(1, 0, 8'h02, 0, 1, "push_02");
    step(1, 1, 8'h77, 0, 1, "replace_top");
    step(0, 1, 8'h00, 0, 1, "pop_after_replace");

    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h80 + i), 0, 1, "refill");
    step(1, 0, 8'hAA, 0, 1, "overflow_again");
    for (int i = 0; i < DEPTH - 5; i++) step(0, 1, 8'h00, 0, 1, "pop_to_5");
    step(1, 0, 8'h99, 0, 0, "reset_with_push");
    step(1, 0, 8'h42, 0, 1, "push_after_reset");

    for (int i = 0; i < 600; i++) begin
      rp = ($urandom_range(0, 99) < 55);
      ro = ($urandom_range(0, 99) < 45);
      step(rp, ro, 8'($urandom), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 63) != 0), "random");
    end

    step(0, 0, 8'h00, 0, 1, "final_idle");
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_scoreboard: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
